// File: rtl/retospect_pkg.sv
// Shared constants for the AER encoder and future spike readout logic.
// Holds the neuron count default, address-width helper and drop counter width.
package retospect_pkg;

    localparam int N_NEURONS_DEF  = 25;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int DROP_CNT_W     = 8;

    // Smallest address width that can index n neurons (at least one bit).
    function automatic int addr_w_for(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/retospect_aer_encoder_if.sv
// Address-event output bus: valid/ready handshake carrying a neuron index.
// The encoder drives it as master; the outbus consumer is the slave.
interface retospect_aer_encoder_if #(
    parameter int ADDR_W = 5
);
    logic              ev_valid;
    logic [ADDR_W-1:0] ev_addr;
    logic              ev_ready;

    modport master (output ev_valid, output ev_addr, input ev_ready);
    modport slave  (input ev_valid, input ev_addr, output ev_ready);
endinterface

// File: rtl/retospect_spike_fifo.sv
// Small synchronous FIFO for queued spike addresses; head is read without a read cycle.
// Latency: push visible at pop_dat the cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module retospect_spike_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
)(
    input  logic             clk,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/retospect_aer_encoder.sv
// Converts per-neuron axon pulses into a lowest-index-first address-event stream.
// Latency: axon pulse to ev_valid is 2 cycles with an idle FIFO; no fall-through.
// Backpressure: full FIFO holds pending bits; a repeat spike on a held bit is dropped and counted.
module retospect_aer_encoder
    import retospect_pkg::*;
#(
    parameter int N_NEURONS  = N_NEURONS_DEF,
    parameter int ADDR_W     = addr_w_for(N_NEURONS),
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int DROP_W     = DROP_CNT_W
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reset_nn,
    input  logic                   config_en,
    input  logic [N_NEURONS-1:0]   axon,
    retospect_aer_encoder_if.master ev,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_cnt
);
    logic [N_NEURONS-1:0] pending;
    logic [N_NEURONS-1:0] axon_eff;
    logic [N_NEURONS-1:0] grant;
    logic [ADDR_W-1:0]    grant_idx;
    logic                 grant_vld;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 arb_en;
    logic                 drop_any;

    assign axon_eff = config_en ? '0 : axon;
    assign pop      = !fifo_empty && ev.ev_ready;
    assign arb_en   = !fifo_full || pop;

    // Scan high to low so the lowest set bit wins.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant_idx = ADDR_W'(i);
                grant_vld = arb_en;
            end
        end
        grant = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            grant[i] = grant_vld && (grant_idx == ADDR_W'(i));
        end
    end

    // A re-spike on the bit granted this cycle re-arms it and is not a loss.
    assign drop_any = |(axon_eff & pending & ~grant);

    always_ff @(posedge clk) begin
        if (reset || reset_nn) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~grant) | axon_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (!reset_nn && drop_any) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

    retospect_spike_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .clear    (reset || reset_nn),
        .push     (grant_vld),
        .push_dat (grant_idx),
        .pop      (pop),
        .pop_dat  (ev.ev_addr),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign ev.ev_valid = !fifo_empty;

endmodule

// File: tb/tb_retospect_aer_encoder.sv
// Directed bench for the AER encoder: latency, arbitration order, backpressure,
// drop counting/saturation, config masking and both reset flavours.
module tb_retospect_aer_encoder;
    import retospect_pkg::*;

    localparam int N  = 25;
    localparam int AW = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic         reset_nn;
    logic         config_en;
    logic [N-1:0] axon;
    logic         overflow;
    logic [7:0]   drop_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    retospect_aer_encoder_if #(.ADDR_W(AW)) ev_if ();

    retospect_aer_encoder #(
        .N_NEURONS  (N),
        .ADDR_W     (AW),
        .FIFO_DEPTH (4),
        .DROP_W     (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .reset_nn  (reset_nn),
        .config_en (config_en),
        .axon      (axon),
        .ev        (ev_if.master),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; reset_nn = 1'b0; config_en = 1'b0; axon = '0;
        ev_if.ev_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_valid", ev_if.ev_valid, 0);
        chk("rst_addr", ev_if.ev_addr, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_cnt, 0);

        // Single spike: two-cycle latency, one beat.
        ev_if.ev_ready = 1'b1;
        axon = 25'd1 << 7;
        step();
        axon = '0;
        chk("single_no_fallthru", ev_if.ev_valid, 0);
        step();
        chk("single_valid", ev_if.ev_valid, 1);
        chk("single_addr", ev_if.ev_addr, 7);
        step();
        chk("single_one_beat", ev_if.ev_valid, 0);

        // Simultaneous spikes come out lowest index first.
        axon = (25'd1 << 3) | (25'd1 << 0) | (25'd1 << 12);
        step();
        axon = '0;
        step();
        chk("sim_addr0", ev_if.ev_addr, 0);
        step();
        chk("sim_addr3", ev_if.ev_addr, 3);
        step();
        chk("sim_addr12", ev_if.ev_addr, 12);
        chk("sim_valid", ev_if.ev_valid, 1);
        step();
        chk("sim_done", ev_if.ev_valid, 0);

        // Backpressure: 1..4 queued, 5 and 6 held pending.
        ev_if.ev_ready = 1'b0;
        axon = 25'h7E;
        step();
        axon = '0;
        repeat (6) step();
        chk("bp_valid", ev_if.ev_valid, 1);
        chk("bp_head", ev_if.ev_addr, 1);
        chk("bp_nodrop", drop_cnt, 0);
        ev_if.ev_ready = 1'b1;
        for (int k = 2; k <= 6; k++) begin
            step();
            chk($sformatf("bp_addr%0d", k), ev_if.ev_addr, k);
        end
        step();
        chk("bp_done", ev_if.ev_valid, 0);
        chk("bp_ovf", overflow, 0);

        // config_en masks axon but the FIFO still drains.
        ev_if.ev_ready = 1'b0;
        axon = (25'd1 << 20) | (25'd1 << 24);
        step();
        axon = '0;
        step();
        step();
        chk("cfg_head", ev_if.ev_addr, 20);
        config_en = 1'b1;
        axon = '1;
        ev_if.ev_ready = 1'b1;
        step();
        chk("cfg_drain24", ev_if.ev_addr, 24);
        step();
        chk("cfg_empty", ev_if.ev_valid, 0);
        repeat (3) step();
        chk("cfg_no_events", ev_if.ev_valid, 0);
        chk("cfg_no_drops", drop_cnt, 0);
        config_en = 1'b0;
        axon = '0;
        repeat (3) step();
        chk("cfg_nothing_pending", ev_if.ev_valid, 0);

        // Drop: full FIFO, axon[2] pulsed twice.
        ev_if.ev_ready = 1'b0;
        axon = 25'h3C00;
        step();
        axon = '0;
        repeat (4) step();
        axon = 25'd1 << 2;
        step();
        chk("drop_first_ok", drop_cnt, 0);
        step();
        chk("drop_cnt1", drop_cnt, 1);
        chk("drop_ovf", overflow, 1);
        repeat (260) step();
        axon = '0;
        chk("drop_sat", drop_cnt, 255);
        chk("drop_head_stable", ev_if.ev_addr, 10);
        ev_if.ev_ready = 1'b1;
        step();
        chk("drain11", ev_if.ev_addr, 11);
        step();
        chk("drain12", ev_if.ev_addr, 12);
        step();
        chk("drain13", ev_if.ev_addr, 13);
        step();
        chk("drain2", ev_if.ev_addr, 2);
        step();
        chk("drain_done", ev_if.ev_valid, 0);

        // reset_nn with 3 queued and 2 pending; counters survive.
        ev_if.ev_ready = 1'b0;
        axon = 25'h3E;
        step();
        axon = '0;
        repeat (3) step();
        chk("nn_head", ev_if.ev_addr, 1);
        reset_nn = 1'b1;
        axon = 25'd1 << 9;
        step();
        reset_nn = 1'b0;
        axon = '0;
        chk("nn_valid", ev_if.ev_valid, 0);
        chk("nn_addr", ev_if.ev_addr, 0);
        chk("nn_drop_kept", drop_cnt, 255);
        chk("nn_ovf_kept", overflow, 1);
        ev_if.ev_ready = 1'b1;
        repeat (4) step();
        chk("nn_pending_gone", ev_if.ev_valid, 0);

        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_drop", drop_cnt, 0);
        chk("rst2_ovf", overflow, 0);
        chk("rst2_valid", ev_if.ev_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
